mult_feeder: RTL and testbench

MULT_FEEDER -- requirements
Module: mult_feeder

---
 rtl/mult_feeder_pkg.sv | 16 +
 rtl/mult_feeder_if.sv | 32 +++
 rtl/mult_feeder_operand_fifo.sv | 83 ++++++++
 rtl/mult_feeder.sv | 126 ++++++++++++
 tb/tb_mult_feeder.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mult_feeder_pkg.sv
// Shared types and default sizing for the multiplier operand feeder.
package mult_pkg;

    localparam int DATA_W_DEF   = 8;
    localparam int DEPTH_DEF    = 4;
    localparam int PIPE_LAT_DEF = 2;
    localparam int JOB_LEN_W    = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

endpackage

// File: rtl/mult_feeder_if.sv
// Job, push and pipe-controller signals of the operand feeder.
// The master modport is the feeder itself; slave is its environment.
interface mult_feeder_if
    import mult_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
);
    logic                 go;
    logic [JOB_LEN_W-1:0] job_len;
    logic                 wr_en;
    logic [DATA_W-1:0]    a_in;
    logic [DATA_W-1:0]    b_in;
    logic                 full;
    logic                 start;
    logic                 can_mult;
    logic                 ld_mult;
    logic [DATA_W-1:0]    mult_a;
    logic [DATA_W-1:0]    mult_b;
    logic                 inner_rst;
    logic                 done;
    logic                 overflow;

    modport master (
        input  go, job_len, wr_en, a_in, b_in, ld_mult,
        output full, start, can_mult, mult_a, mult_b, inner_rst, done, overflow
    );

    modport slave (
        output go, job_len, wr_en, a_in, b_in, ld_mult,
        input  full, start, can_mult, mult_a, mult_b, inner_rst, done, overflow
    );
endinterface

// File: rtl/mult_feeder_operand_fifo.sv
// Operand-pair FIFO with a registered head and a sticky overflow flag.
module operand_fifo
    import mult_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [DATA_W-1:0]        a_i,
    input  logic [DATA_W-1:0]        b_i,
    input  logic                     pop_i,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [DATA_W-1:0]        head_a_o,
    output logic [DATA_W-1:0]        head_b_o,
    output logic                     overflow_o
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [2*DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]      count_q, count_d;
    logic [2*DATA_W-1:0] head_q, head_d;
    logic                overflow_q, overflow_d;
    logic                push_ok, pop_ok;

    assign full_o     = (count_q == (PTR_W+1)'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign push_ok    = push_i && !full_o;
    assign pop_ok     = pop_i && !empty_o;
    assign count_o    = count_q;
    assign head_a_o   = head_q[2*DATA_W-1:DATA_W];
    assign head_b_o   = head_q[DATA_W-1:0];
    assign overflow_o = overflow_q;

    // Next pointers/count; the head register preloads the entry that will be at the front next cycle.
    always_comb begin
        wr_ptr_d   = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop_ok  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | (push_i && full_o);
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // A push landing in the slot that becomes the front bypasses the array.
        if (count_d == '0) begin
            head_d = '0;
        end else if (push_ok && (wr_ptr_q == rd_ptr_d)) begin
            head_d = {a_i, b_i};
        end else begin
            head_d = mem[rd_ptr_d];
        end
    end

    // Pointer, count, head and overflow registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            head_q     <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            head_q     <= head_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage array write; contents are don't-care once the pointers reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= {a_i, b_i};
        end
    end
endmodule

// File: rtl/mult_feeder.sv
// Job sequencer feeding operand pairs from a FIFO to a multiplier pipe controller.
module mult_feeder
    import mult_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int DEPTH    = DEPTH_DEF,
    parameter int PIPE_LAT = PIPE_LAT_DEF
) (
    input  logic          clk,
    input  logic          rst,
    mult_feeder_if.master bus
);
    localparam int LAT_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    state_e               state_q, state_d;
    logic [JOB_LEN_W-1:0] job_len_q, job_len_d;
    logic [JOB_LEN_W-1:0] issued_q, issued_d;
    logic [LAT_W-1:0]     lat_q, lat_d;
    logic                 done_q, done_d;
    logic                 start_c, can_mult_c, pop_c;
    logic                 fifo_full, fifo_empty, fifo_overflow;
    logic [$clog2(DEPTH):0] fifo_count;
    logic [DATA_W-1:0]    head_a, head_b;
    logic [JOB_LEN_W:0]   fill_cnt, fill_target;

    assign pop_c       = bus.ld_mult && can_mult_c;
    assign fill_cnt    = (JOB_LEN_W+1)'(fifo_count);
    assign fill_target = ({1'b0, job_len_q} < (JOB_LEN_W+1)'(DEPTH)) ?
                         {1'b0, job_len_q} : (JOB_LEN_W+1)'(DEPTH);

    operand_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_i     (bus.wr_en),
        .a_i        (bus.a_in),
        .b_i        (bus.b_in),
        .pop_i      (pop_c),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (fifo_count),
        .head_a_o   (head_a),
        .head_b_o   (head_b),
        .overflow_o (fifo_overflow)
    );

    // Next-state, job counters and handshake outputs.
    always_comb begin
        state_d    = state_q;
        job_len_d  = job_len_q;
        issued_d   = issued_q;
        lat_d      = lat_q;
        done_d     = 1'b0;
        start_c    = 1'b0;
        can_mult_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.go) begin
                    if (bus.job_len != '0) begin
                        job_len_d = bus.job_len;
                        issued_d  = '0;
                        state_d   = ST_FILL;
                    end else begin
                        // Empty job completes immediately.
                        done_d = 1'b1;
                    end
                end
            end
            ST_FILL: begin
                if (fill_cnt >= fill_target) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                start_c    = 1'b1;
                can_mult_c = !fifo_empty;
                if (bus.ld_mult && !fifo_empty) begin
                    issued_d = issued_q + 1'b1;
                    if (issued_d == job_len_q) begin
                        lat_d   = '0;
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                start_c = 1'b1;
                // Wait for the pipe to retire before flushing it.
                if (lat_q == LAT_W'(PIPE_LAT - 1)) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            job_len_q <= '0;
            issued_q  <= '0;
            lat_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            job_len_q <= job_len_d;
            issued_q  <= issued_d;
            lat_q     <= lat_d;
            done_q    <= done_d;
        end
    end

    assign bus.full      = fifo_full;
    assign bus.overflow  = fifo_overflow;
    assign bus.start     = start_c;
    assign bus.can_mult  = can_mult_c;
    assign bus.mult_a    = head_a;
    assign bus.mult_b    = head_b;
    assign bus.done      = done_q;
    assign bus.inner_rst = done_q;
endmodule

// File: tb/tb_mult_feeder.sv
// Self-checking bench for mult_feeder: vector table, directed sequences, random vs model.
module tb_mult_feeder;
    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int PL    = 2;

    logic clk;
    logic rst;
    int   checks = 0;
    int   passed = 0;

    mult_feeder_if #(.DATA_W(DW)) bus ();

    mult_feeder #(.DATA_W(DW), .DEPTH(DEPTH), .PIPE_LAT(PL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          wr;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic          ld;
        logic          exp_full;
        logic          exp_ovf;
        logic [DW-1:0] exp_a;
        logic [DW-1:0] exp_b;
    } vec_t;

    vec_t vecs [7];

    // Reference model: queue of pairs plus job bookkeeping.
    logic [2*DW-1:0] m_q [$];
    bit m_ovf, m_active, m_fill_ok, m_done;
    int m_need, m_issued, m_drain;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    task automatic idle_in();
        bus.go = 1'b0; bus.job_len = '0; bus.wr_en = 1'b0;
        bus.a_in = '0; bus.b_in = '0; bus.ld_mult = 1'b0;
    endtask

    task automatic push(input int a, input int b);
        bus.wr_en = 1'b1; bus.a_in = DW'(a); bus.b_in = DW'(b);
    endtask

    task automatic do_reset();
        rst = 1'b0; idle_in();
        nxt(); nxt();
        rst = 1'b1;
    endtask

    task automatic m_clear();
        m_q.delete();
        m_ovf = 0; m_active = 0; m_fill_ok = 0; m_done = 0;
        m_need = 0; m_issued = 0; m_drain = 0;
    endtask

    // Advance the model across one rising edge with the given inputs.
    task automatic m_step(input bit r, input bit go, input int jl, input bit wr,
                          input logic [DW-1:0] a, input logic [DW-1:0] b, input bit ld);
        bit can, pop, push_ok, full_now, done_n;
        int tgt;
        if (!r) begin
            m_clear();
            return;
        end
        can      = m_active && m_fill_ok && (m_issued < m_need) && (m_q.size() > 0);
        pop      = ld && can;
        full_now = (m_q.size() == DEPTH);
        push_ok  = wr && !full_now;
        if (wr && full_now) m_ovf = 1;
        done_n = 0;
        if (!m_active) begin
            if (go) begin
                if (jl != 0) begin
                    m_active = 1; m_need = jl; m_issued = 0; m_fill_ok = 0; m_drain = 0;
                end else begin
                    done_n = 1;
                end
            end
        end else if (!m_fill_ok) begin
            tgt = (m_need < DEPTH) ? m_need : DEPTH;
            if (m_q.size() >= tgt) m_fill_ok = 1;
        end else if (m_issued < m_need) begin
            if (pop) m_issued++;
        end else begin
            m_drain++;
            if (m_drain == PL) begin
                m_active = 0; done_n = 1;
            end
        end
        m_done = done_n;
        if (pop) void'(m_q.pop_front());
        if (push_ok) m_q.push_back({a, b});
    endtask

    initial begin
        clk = 1'b0;
        rst = 1'b0;
        idle_in();

        // Reset state
        nxt(); nxt();
        chk("rst_start", bus.start, 0);      chk("rst_can", bus.can_mult, 0);
        chk("rst_done", bus.done, 0);        chk("rst_irst", bus.inner_rst, 0);
        chk("rst_full", bus.full, 0);        chk("rst_ovf", bus.overflow, 0);
        chk("rst_a", bus.mult_a, 0);         chk("rst_b", bus.mult_b, 0);
        $display("reset state checked");
        rst = 1'b1;

        // Table: push past full while idle; ld_mult must be ignored.
        vecs[0] = '{1'b1, 8'd1, 8'd2,  1'b0, 1'b0, 1'b0, 8'd1, 8'd2};
        vecs[1] = '{1'b1, 8'd3, 8'd4,  1'b0, 1'b0, 1'b0, 8'd1, 8'd2};
        vecs[2] = '{1'b0, 8'd0, 8'd0,  1'b1, 1'b0, 1'b0, 8'd1, 8'd2};
        vecs[3] = '{1'b1, 8'd5, 8'd6,  1'b0, 1'b0, 1'b0, 8'd1, 8'd2};
        vecs[4] = '{1'b1, 8'd7, 8'd8,  1'b0, 1'b1, 1'b0, 8'd1, 8'd2};
        vecs[5] = '{1'b1, 8'd9, 8'd10, 1'b0, 1'b1, 1'b1, 8'd1, 8'd2};
        vecs[6] = '{1'b0, 8'd0, 8'd0,  1'b1, 1'b1, 1'b1, 8'd1, 8'd2};
        for (int i = 0; i < 7; i++) begin
            bus.wr_en = vecs[i].wr; bus.a_in = vecs[i].a; bus.b_in = vecs[i].b;
            bus.ld_mult = vecs[i].ld;
            nxt();
            chk("vec_full", bus.full, vecs[i].exp_full);
            chk("vec_ovf", bus.overflow, vecs[i].exp_ovf);
            chk("vec_a", bus.mult_a, vecs[i].exp_a);
            chk("vec_b", bus.mult_b, vecs[i].exp_b);
            chk("vec_start", bus.start, 0);
            $display("vec %0d: wr=%0d ld=%0d full=%0d ovf=%0d", i, vecs[i].wr, vecs[i].ld,
                     bus.full, bus.overflow);
        end
        idle_in();
        do_reset();

        // Basic two-pair job with ld_mult held high.
        push(3, 4); nxt(); push(5, 6); nxt();
        bus.wr_en = 1'b0; bus.go = 1'b1; bus.job_len = 8'd2; bus.ld_mult = 1'b1; nxt();
        bus.go = 1'b0;
        chk("a_fill_start", bus.start, 0); nxt();
        chk("a_start", bus.start, 1); chk("a_can0", bus.can_mult, 1);
        chk("a_a0", bus.mult_a, 3); chk("a_b0", bus.mult_b, 4); nxt();
        chk("a_can1", bus.can_mult, 1); chk("a_a1", bus.mult_a, 5); chk("a_b1", bus.mult_b, 6); nxt();
        chk("a_dr_can", bus.can_mult, 0); chk("a_dr_start", bus.start, 1); chk("a_dr_done0", bus.done, 0); nxt();
        chk("a_dr_start1", bus.start, 1); chk("a_dr_done1", bus.done, 0); nxt();
        chk("a_done", bus.done, 1); chk("a_irst", bus.inner_rst, 1); chk("a_idle_start", bus.start, 0); nxt();
        chk("a_done_low", bus.done, 0);
        bus.ld_mult = 1'b0;
        $display("job of 2 pairs sequenced");
        do_reset();

        // Full FIFO in RUN: simultaneous push and pop.
        for (int k = 0; k < 4; k++) begin push(10 + 2*k, 11 + 2*k); nxt(); end
        bus.wr_en = 1'b0; bus.go = 1'b1; bus.job_len = 8'd4; nxt();
        bus.go = 1'b0; nxt();
        chk("b_start", bus.start, 1); chk("b_full", bus.full, 1); chk("b_a", bus.mult_a, 10);
        push(20, 21); bus.ld_mult = 1'b1; nxt();
        chk("b_full_after", bus.full, 0); chk("b_ovf", bus.overflow, 1);
        chk("b_head_a", bus.mult_a, 12); chk("b_head_b", bus.mult_b, 13);
        push(22, 23); bus.ld_mult = 1'b0; nxt();
        chk("b_refull", bus.full, 1); chk("b_head_keep", bus.mult_a, 12);
        idle_in();
        $display("push rejected during pop from full FIFO");
        do_reset();

        // Zero-length job.
        bus.go = 1'b1; bus.job_len = 8'd0; nxt();
        bus.go = 1'b0;
        chk("c_done", bus.done, 1); chk("c_irst", bus.inner_rst, 1); chk("c_start", bus.start, 0); nxt();
        chk("c_done_low", bus.done, 0); chk("c_start1", bus.start, 0); nxt();
        chk("c_start2", bus.start, 0);
        $display("zero-length job completed");
        do_reset();

        // Reset mid-job.
        for (int k = 0; k < 3; k++) begin push(k + 1, k + 1); nxt(); end
        bus.wr_en = 1'b0; bus.go = 1'b1; bus.job_len = 8'd3; nxt();
        bus.go = 1'b0; nxt();
        chk("d_can", bus.can_mult, 1); bus.ld_mult = 1'b1; nxt();
        chk("d_can1", bus.can_mult, 1); bus.ld_mult = 1'b0; rst = 1'b0; nxt();
        chk("d_start", bus.start, 0); chk("d_can_rst", bus.can_mult, 0);
        chk("d_done", bus.done, 0);   chk("d_irst", bus.inner_rst, 0);
        chk("d_full", bus.full, 0);   chk("d_ovf", bus.overflow, 0);
        chk("d_a", bus.mult_a, 0);    chk("d_b", bus.mult_b, 0);
        rst = 1'b1; bus.go = 1'b1; bus.job_len = 8'd1; nxt();
        bus.go = 1'b0;
        for (int k = 0; k < 3; k++) begin
            nxt(); chk("d_empty_start", bus.start, 0); chk("d_nodone", bus.done, 0);
        end
        $display("mid-job reset aborted job");
        do_reset();

        // ld_mult on an empty FIFO in RUN.
        for (int k = 0; k < 4; k++) begin push(2*k + 1, 2*k + 2); nxt(); end
        bus.wr_en = 1'b0; bus.go = 1'b1; bus.job_len = 8'd5; nxt();
        bus.go = 1'b0; nxt();
        bus.ld_mult = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("e_can", bus.can_mult, 1); chk("e_a", bus.mult_a, 2*k + 1); chk("e_b", bus.mult_b, 2*k + 2);
            nxt();
        end
        for (int j = 0; j < 3; j++) begin
            chk("e_empty_start", bus.start, 1); chk("e_empty_can", bus.can_mult, 0);
            chk("e_empty_done", bus.done, 0);
            if (j == 2) push(9, 9);
            nxt();
        end
        bus.wr_en = 1'b0;
        chk("e_last_can", bus.can_mult, 1); chk("e_last_a", bus.mult_a, 9); nxt();
        bus.ld_mult = 1'b0;
        chk("e_dr_start", bus.start, 1); chk("e_dr_done", bus.done, 0); nxt();
        chk("e_dr_start1", bus.start, 1); chk("e_dr_done1", bus.done, 0); nxt();
        chk("e_done", bus.done, 1);
        $display("empty-FIFO ld_mult ignored");
        do_reset();

        // Random stimulus against the reference model.
        m_clear();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bit r, g, w, l;
            int jl;
            logic [DW-1:0] ra, rb;
            bit e_start, e_can;
            e_start = m_active && m_fill_ok;
            e_can   = e_start && (m_issued < m_need) && (m_q.size() > 0);
            chk("r_start", bus.start, e_start);
            chk("r_can", bus.can_mult, e_can);
            chk("r_done", bus.done, m_done);
            chk("r_irst", bus.inner_rst, m_done);
            chk("r_full", bus.full, m_q.size() == DEPTH);
            chk("r_ovf", bus.overflow, m_ovf);
            if (m_q.size() > 0) begin
                chk("r_a", bus.mult_a, m_q[0][2*DW-1:DW]);
                chk("r_b", bus.mult_b, m_q[0][DW-1:0]);
            end
            if (m_done) $display("random job complete at cycle %0d", cyc);
            r  = ($urandom_range(0, 199) != 0);
            g  = ($urandom_range(0, 5) == 0);
            jl = $urandom_range(0, 7);
            w  = $urandom_range(0, 1) == 1;
            l  = $urandom_range(0, 1) == 1;
            ra = DW'($urandom_range(0, 255));
            rb = DW'($urandom_range(0, 255));
            rst = r; bus.go = g; bus.job_len = 8'(jl); bus.wr_en = w;
            bus.a_in = ra; bus.b_in = rb; bus.ld_mult = l;
            m_step(r, g, jl, w, ra, rb, l);
            nxt();
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
